// File: rtl/cpu_pkg.sv
// Shared types and constants for the Thumb-style core pipeline.
// Holds the writeback FSM state type, default widths and NZCV bit positions.
package cpu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int HALF_W_DEF  = 16;
  localparam int RADDR_W_DEF = 4;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LO_WAIT = 2'd1,
    ST_HI_WAIT = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_half_assembler.sv
// Load data assembler: holds the low 16-bit beat and joins it with the live high beat.
// The high half is not stored because the word is written on the same beat it arrives.
module half_assembler
  import cpu_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lo_we_i,
  input  logic [HALF_W-1:0]   half_i,
  output logic [2*HALF_W-1:0] word_o
);

  logic [HALF_W-1:0] lo_q;
  logic [HALF_W-1:0] lo_d;

  // Low-half next-state selection
  always_comb begin
    lo_d = lo_q;
    if (lo_we_i) begin
      lo_d = half_i;
    end else begin
      lo_d = lo_q;
    end
  end

  // Low-half storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_q <= '0;
    end else begin
      lo_q <= lo_d;
    end
  end

  assign word_o = {half_i, lo_q};

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: ALU/load writeback arbitration, load beat FSM, skid entry and NZCV.
// Optional bypass outputs are enabled by defining WB_FORWARD_EN.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int HALF_W  = HALF_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DATA_W-1:0]  data_calc_i,
  input  logic               mem_to_reg_i,
  input  logic [RADDR_W-1:0] rf_wr_select_i,
  input  logic               rf_wr_en_i,
  input  logic [3:0]         alu_status_i,
  input  logic               status_we_i,
  input  logic [HALF_W-1:0]  mem_rdata_i,
  input  logic               mem_rvalid_i,
  output logic [DATA_W-1:0]  rf_wr_data_o,
  output logic [RADDR_W-1:0] rf_wr_addr_o,
  output logic               rf_wr_en_o,
  output logic [3:0]         status_o,
  output logic               load_busy_o
`ifdef WB_FORWARD_EN
  ,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0]  fwd_data_o
`endif
);

  wb_state_t          state_q, state_d;
  logic [RADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [RADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic               wr_en_q, wr_en_d;
  logic [RADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [3:0]         status_q, status_d;

  logic               alu_wr_s;
  logic               load_req_s;
  logic               lo_we_s;
  logic               load_done_s;
  logic [DATA_W-1:0]  asm_word_s;

  assign alu_wr_s   = rf_wr_en_i & ~mem_to_reg_i;
  assign load_req_s = rf_wr_en_i & mem_to_reg_i;

  half_assembler #(
    .HALF_W (HALF_W)
  ) u_half_assembler (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .lo_we_i (lo_we_s),
    .half_i  (mem_rdata_i),
    .word_o  (asm_word_s)
  );

  // Load FSM next state and write-port arbitration (load > skid > new ALU write)
  always_comb begin
    state_d      = state_q;
    ld_addr_d    = ld_addr_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    lo_we_s      = 1'b0;
    load_done_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_req_s) begin
          state_d   = ST_LO_WAIT;
          ld_addr_d = rf_wr_select_i;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LO_WAIT: begin
        if (mem_rvalid_i) begin
          lo_we_s = 1'b1;
          state_d = ST_HI_WAIT;
        end else begin
          state_d = ST_LO_WAIT;
        end
      end
      ST_HI_WAIT: begin
        if (mem_rvalid_i) begin
          load_done_s = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_HI_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A displaced ALU write always parks in the skid entry so nothing drops
    if (load_done_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ld_addr_q;
      wr_data_d = asm_word_s;
      if (alu_wr_s) begin
        skid_valid_d = 1'b1;
        skid_addr_d  = rf_wr_select_i;
        skid_data_d  = data_calc_i;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (skid_valid_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = skid_addr_q;
      wr_data_d = skid_data_q;
      if (alu_wr_s) begin
        skid_valid_d = 1'b1;
        skid_addr_d  = rf_wr_select_i;
        skid_data_d  = data_calc_i;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else if (alu_wr_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rf_wr_select_i;
      wr_data_d = data_calc_i;
    end else begin
      wr_en_d   = 1'b0;
    end
  end

  // Status register next state
  always_comb begin
    status_d = status_q;
    if (status_we_i) begin
      status_d = alu_status_i;
    end else begin
      status_d = status_q;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ld_addr_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      status_q     <= 4'b0000;
    end else begin
      state_q      <= state_d;
      ld_addr_q    <= ld_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      status_q     <= status_d;
    end
  end

  assign rf_wr_en_o   = wr_en_q;
  assign rf_wr_addr_o = wr_addr_q;
  assign rf_wr_data_o = wr_data_q;
  assign status_o     = status_q;
  assign load_busy_o  = (state_q != ST_IDLE) | skid_valid_q;

`ifdef WB_FORWARD_EN
  // Bypass sees the value the register file will take at the next edge
  assign fwd_valid_o = wr_en_d & ~rst_i;
  assign fwd_addr_o  = wr_addr_d;
  assign fwd_data_o  = wr_data_d;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_writeback_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_calc_i;
  logic        mem_to_reg_i;
  logic [3:0]  rf_wr_select_i;
  logic        rf_wr_en_i;
  logic [3:0]  alu_status_i;
  logic        status_we_i;
  logic [15:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic [31:0] rf_wr_data_o;
  logic [3:0]  rf_wr_addr_o;
  logic        rf_wr_en_o;
  logic [3:0]  status_o;
  logic        load_busy_o;
`ifdef WB_FORWARD_EN
  logic        fwd_valid_o;
  logic [3:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int pulses  = 0;

  always #5 clk_i = ~clk_i;

  writeback_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_calc_i    (data_calc_i),
    .mem_to_reg_i   (mem_to_reg_i),
    .rf_wr_select_i (rf_wr_select_i),
    .rf_wr_en_i     (rf_wr_en_i),
    .alu_status_i   (alu_status_i),
    .status_we_i    (status_we_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .rf_wr_data_o   (rf_wr_data_o),
    .rf_wr_addr_o   (rf_wr_addr_o),
    .rf_wr_en_o     (rf_wr_en_o),
    .status_o       (status_o),
    .load_busy_o    (load_busy_o)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid_o    (fwd_valid_o),
    .fwd_addr_o     (fwd_addr_o),
    .fwd_data_o     (fwd_data_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
    if (rf_wr_en_o === 1'b1) pulses++;
  endtask

  task automatic idle_inputs();
    data_calc_i    = 32'h0;
    mem_to_reg_i   = 1'b0;
    rf_wr_select_i = 4'd0;
    rf_wr_en_i     = 1'b0;
    alu_status_i   = 4'b0000;
    status_we_i    = 1'b0;
    mem_rdata_i    = 16'h0;
    mem_rvalid_i   = 1'b0;
  endtask

  task automatic alu_wr(input logic [3:0] a, input logic [31:0] d);
    mem_to_reg_i   = 1'b0;
    rf_wr_en_i     = 1'b1;
    rf_wr_select_i = a;
    data_calc_i    = d;
  endtask

  task automatic load_start(input logic [3:0] a);
    mem_to_reg_i   = 1'b1;
    rf_wr_en_i     = 1'b1;
    rf_wr_select_i = a;
    data_calc_i    = 32'hBAD0BAD0;
  endtask

  task automatic beat(input logic [15:0] h);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = h;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_en",   {31'd0, rf_wr_en_o}, 32'd0);
    chk("rst_data", rf_wr_data_o, 32'd0);
    chk("rst_addr", {28'd0, rf_wr_addr_o}, 32'd0);
    chk("rst_stat", {28'd0, status_o}, 32'd0);
    chk("rst_busy", {31'd0, load_busy_o}, 32'd0);
`ifdef WB_FORWARD_EN
    alu_wr(4'd9, 32'h1);
    #1 chk("rst_fwd", {31'd0, fwd_valid_o}, 32'd0);
    idle_inputs();
`endif
    rst_i = 1'b0;

    // ALU write
    alu_wr(4'd5, 32'hDEADBEEF);
`ifdef WB_FORWARD_EN
    #1 chk("fwd_valid", {31'd0, fwd_valid_o}, 32'd1);
    chk("fwd_data", fwd_data_o, 32'hDEADBEEF);
`endif
    step();
    chk("alu_en",   {31'd0, rf_wr_en_o}, 32'd1);
    chk("alu_addr", {28'd0, rf_wr_addr_o}, 32'd5);
    chk("alu_data", rf_wr_data_o, 32'hDEADBEEF);
    idle_inputs();
    step();
    chk("alu_en_off", {31'd0, rf_wr_en_o}, 32'd0);

    // Load with back-to-back beats
    load_start(4'd3);
    step();
    chk("ld_busy0", {31'd0, load_busy_o}, 32'd1);
    chk("ld_en0",   {31'd0, rf_wr_en_o}, 32'd0);
    idle_inputs();
    beat(16'h5678);
    step();
    chk("ld_busy1", {31'd0, load_busy_o}, 32'd1);
    chk("ld_en1",   {31'd0, rf_wr_en_o}, 32'd0);
    beat(16'h1234);
    step();
    chk("ld_en",   {31'd0, rf_wr_en_o}, 32'd1);
    chk("ld_addr", {28'd0, rf_wr_addr_o}, 32'd3);
    chk("ld_data", rf_wr_data_o, 32'h12345678);
    chk("ld_busy_done", {31'd0, load_busy_o}, 32'd0);
    idle_inputs();
    step();
    chk("ld_en_off", {31'd0, rf_wr_en_o}, 32'd0);

    // Load with gaps and a stray beat before it
    pulses = 0;
    beat(16'hFFFF);
    step();
    chk("stray_busy", {31'd0, load_busy_o}, 32'd0);
    idle_inputs();
    load_start(4'd7);
    step();
    idle_inputs();
    step();
    step();
    beat(16'hAAAA);
    step();
    idle_inputs();
    step();
    step();
    chk("gap_busy", {31'd0, load_busy_o}, 32'd1);
    beat(16'h5555);
    step();
    chk("gap_addr", {28'd0, rf_wr_addr_o}, 32'd7);
    chk("gap_data", rf_wr_data_o, 32'h5555AAAA);
    idle_inputs();
    step();
    step();
    chk("gap_pulses", pulses, 32'd1);

    // Collision, then a second ALU write while the skid entry is occupied
    load_start(4'd2);
    step();
    idle_inputs();
    beat(16'h0001);
    step();
    pulses = 0;
    beat(16'h0002);
    alu_wr(4'd1, 32'h00000007);
    step();
    chk("col_addr0", {28'd0, rf_wr_addr_o}, 32'd2);
    chk("col_data0", rf_wr_data_o, 32'h00020001);
    chk("col_busy0", {31'd0, load_busy_o}, 32'd1);
    idle_inputs();
    alu_wr(4'd4, 32'h00000044);
    step();
    chk("col_addr1", {28'd0, rf_wr_addr_o}, 32'd1);
    chk("col_data1", rf_wr_data_o, 32'h00000007);
    chk("col_busy1", {31'd0, load_busy_o}, 32'd1);
    idle_inputs();
    step();
    chk("col_addr2", {28'd0, rf_wr_addr_o}, 32'd4);
    chk("col_data2", rf_wr_data_o, 32'h00000044);
    chk("col_busy2", {31'd0, load_busy_o}, 32'd0);
    step();
    chk("col_en_off", {31'd0, rf_wr_en_o}, 32'd0);
    chk("col_pulses", pulses, 32'd3);

    // Status register
    status_we_i  = 1'b1;
    alu_status_i = 4'b1010;
    step();
    chk("stat_load", {28'd0, status_o}, 32'hA);
    status_we_i  = 1'b0;
    alu_status_i = 4'b0101;
    step();
    chk("stat_hold", {28'd0, status_o}, 32'hA);
    idle_inputs();

    // Reset while waiting for the high half
    load_start(4'd6);
    step();
    idle_inputs();
    beat(16'hCAFE);
    step();
    idle_inputs();
    chk("hrst_busy_pre", {31'd0, load_busy_o}, 32'd1);
    pulses = 0;
    rst_i = 1'b1;
    #1;
    chk("hrst_busy", {31'd0, load_busy_o}, 32'd0);
    chk("hrst_en",   {31'd0, rf_wr_en_o}, 32'd0);
    chk("hrst_data", rf_wr_data_o, 32'd0);
    chk("hrst_addr", {28'd0, rf_wr_addr_o}, 32'd0);
    chk("hrst_stat", {28'd0, status_o}, 32'd0);
    step();
    rst_i = 1'b0;
    beat(16'hBEEF);
    step();
    idle_inputs();
    step();
    chk("hrst_pulses", pulses, 32'd0);
    chk("hrst_busy_post", {31'd0, load_busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
